uart_dac_player: RTL and testbench



---
 rtl/dac_player_pkg.sv | 33 +++
 rtl/uart_dac_player_if.sv | 26 ++
 rtl/uart_dac_player_uart_rx.sv | 121 ++++++++++++
 rtl/uart_dac_player.sv | 199 +++++++++++++++++++
 tb/tb_uart_dac_player.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/dac_player_pkg.sv
// Shared types and framing constants for the UART-to-DAC playback path.
package dac_player_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    typedef enum logic {
        PRIME = 1'b0,
        PLAY  = 1'b1
    } player_state_t;

    typedef enum logic {
        WAIT_H = 1'b0,
        WAIT_L = 1'b1
    } asm_state_t;

    localparam int          HI_MARK      = 7;
    localparam int          RSVD         = 6;
    localparam logic [11:0] DAC_MIDSCALE = 12'h800;

    function automatic logic is_hi_byte(input logic [7:0] b);
        return b[HI_MARK] && !b[RSVD];
    endfunction

    function automatic logic is_lo_byte(input logic [7:0] b);
        return !b[HI_MARK] && !b[RSVD];
    endfunction

endpackage

// File: rtl/uart_dac_player_if.sv
// Host-link and DAC-side signals of the playback block.
interface uart_dac_player_if #(
    parameter int RESOLUTION = 12,
    parameter int FIFO_DEPTH = 16
);
    localparam int LEVEL_W = $clog2(FIFO_DEPTH) + 1;

    logic                  rx_i;
    logic                  en_i;
    logic [RESOLUTION-1:0] dac_o;
    logic                  playing_o;
    logic [LEVEL_W-1:0]    level_o;
    logic                  underflow_o;
    logic                  overflow_o;
    logic                  frame_err_o;

    modport master (
        output rx_i, en_i,
        input  dac_o, playing_o, level_o, underflow_o, overflow_o, frame_err_o
    );

    modport slave (
        input  rx_i, en_i,
        output dac_o, playing_o, level_o, underflow_o, overflow_o, frame_err_o
    );
endinterface

// File: rtl/uart_dac_player_uart_rx.sv
// 8N1 UART byte receiver with input synchronizer; stop-bit errors drop the byte.
module uart_rx
    import dac_player_pkg::*;
#(
    parameter int CLKS_PER_BIT = 319
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       rx_i,
    output logic [7:0] byte_o,
    output logic       byte_valid_o,
    output logic       frame_err_o
);
    localparam int               CNT_W   = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_0   = {CNT_W{1'b0}};

    logic [1:0]       sync_r;
    logic             prev_r;
    logic             rx_s;
    rx_state_t        state_r, state_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic [2:0]       bit_r, bit_s;
    logic [7:0]       shift_r, shift_s;
    logic             valid_r, valid_s;
    logic             ferr_r, ferr_s;

    assign rx_s = sync_r[1];

    // Next-state logic: bit timing counts from the detected falling edge.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        bit_s   = bit_r;
        shift_s = shift_r;
        valid_s = 1'b0;
        ferr_s  = 1'b0;
        case (state_r)
            IDLE: begin
                cnt_s = CNT_0;
                if (prev_r && !rx_s) begin
                    state_s = START;
                end else begin
                    state_s = IDLE;
                end
            end
            START: begin
                if (cnt_r == HALF_M1) begin
                    cnt_s = CNT_0;
                    bit_s = 3'd0;
                    if (!rx_s) begin
                        state_s = DATA;
                    end else begin
                        state_s = IDLE;
                    end
                end else begin
                    cnt_s = cnt_r + CNT_W'(1'b1);
                end
            end
            DATA: begin
                if (cnt_r == FULL_M1) begin
                    cnt_s   = CNT_0;
                    shift_s = {rx_s, shift_r[7:1]};
                    if (bit_r == 3'd7) begin
                        state_s = STOP;
                    end else begin
                        bit_s = bit_r + 3'd1;
                    end
                end else begin
                    cnt_s = cnt_r + CNT_W'(1'b1);
                end
            end
            STOP: begin
                if (cnt_r == FULL_M1) begin
                    cnt_s   = CNT_0;
                    state_s = IDLE;
                    if (rx_s) begin
                        valid_s = 1'b1;
                    end else begin
                        ferr_s = 1'b1;
                    end
                end else begin
                    cnt_s = cnt_r + CNT_W'(1'b1);
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = CNT_0;
            end
        endcase
    end

    // Synchronizer, receiver state and registered byte outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_r  <= 2'b11;
            prev_r  <= 1'b1;
            state_r <= IDLE;
            cnt_r   <= CNT_0;
            bit_r   <= 3'd0;
            shift_r <= 8'h00;
            valid_r <= 1'b0;
            ferr_r  <= 1'b0;
        end else begin
            sync_r  <= {sync_r[0], rx_i};
            prev_r  <= rx_s;
            state_r <= state_s;
            cnt_r   <= cnt_s;
            bit_r   <= bit_s;
            shift_r <= shift_s;
            valid_r <= valid_s;
            ferr_r  <= ferr_s;
        end
    end

    assign byte_o       = shift_r;
    assign byte_valid_o = valid_r;
    assign frame_err_o  = ferr_r;

endmodule

// File: rtl/uart_dac_player.sv
// Host-to-DAC playback: UART bytes are framed into 12-bit samples, buffered
// in a FIFO and replayed to the R-2R ladder at a fixed sample rate.
module uart_dac_player
    import dac_player_pkg::*;
#(
    parameter int CLK_FREQ    = 36_750_000,
    parameter int BAUD        = 115_200,
    parameter int SAMPLE_FREQ = 4_000,
    parameter int RESOLUTION  = 12,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    uart_dac_player_if.slave bus
);
    localparam int            CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int            TICK         = CLK_FREQ / SAMPLE_FREQ;
    localparam int            AW           = $clog2(FIFO_DEPTH);
    localparam int            TW           = $clog2(TICK);
    localparam logic [TW-1:0] TICK_LAST    = TW'(TICK - 1);
    localparam logic [TW-1:0] TICK_0       = {TW{1'b0}};
    localparam logic [AW:0]   PTR_0        = {(AW + 1){1'b0}};
    localparam logic [AW:0]   PRIME_LEVEL  = (AW + 1)'(FIFO_DEPTH / 2);

    logic [7:0] rx_byte_s;
    logic       rx_valid_s;
    logic       rx_ferr_s;

    uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .rx_i         (bus.rx_i),
        .byte_o       (rx_byte_s),
        .byte_valid_o (rx_valid_s),
        .frame_err_o  (rx_ferr_s)
    );

    asm_state_t            asm_state_r, asm_state_s;
    logic [5:0]            hi_r, hi_s;
    logic                  push_s, asm_err_s;
    logic                  push_r, frame_err_r;
    logic [RESOLUTION-1:0] push_data_r;

    // Sample assembler: a low byte completes the frame, stray bytes flag errors.
    always_comb begin
        asm_state_s = asm_state_r;
        hi_s        = hi_r;
        push_s      = 1'b0;
        asm_err_s   = 1'b0;
        if (rx_valid_s) begin
            case (asm_state_r)
                WAIT_H: begin
                    if (is_hi_byte(rx_byte_s)) begin
                        hi_s        = rx_byte_s[5:0];
                        asm_state_s = WAIT_L;
                    end else begin
                        asm_err_s = 1'b1;
                    end
                end
                WAIT_L: begin
                    if (is_lo_byte(rx_byte_s)) begin
                        push_s      = 1'b1;
                        asm_state_s = WAIT_H;
                    end else if (is_hi_byte(rx_byte_s)) begin
                        asm_err_s = 1'b1;
                        hi_s      = rx_byte_s[5:0];
                    end else begin
                        asm_err_s   = 1'b1;
                        asm_state_s = WAIT_H;
                    end
                end
                default: asm_state_s = WAIT_H;
            endcase
        end else begin
            asm_state_s = asm_state_r;
        end
    end

    // Assembler state and the one-cycle-delayed push request.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            asm_state_r <= WAIT_H;
            hi_r        <= 6'd0;
            push_r      <= 1'b0;
            push_data_r <= {RESOLUTION{1'b0}};
            frame_err_r <= 1'b0;
        end else begin
            asm_state_r <= asm_state_s;
            hi_r        <= hi_s;
            push_r      <= push_s;
            push_data_r <= {hi_r, rx_byte_s[5:0]};
            frame_err_r <= rx_ferr_s | asm_err_s;
        end
    end

    logic [RESOLUTION-1:0] mem_r [FIFO_DEPTH];
    logic [AW:0]           wr_ptr_r, rd_ptr_r, wr_ptr_s, rd_ptr_s, level_r;
    logic [TW-1:0]         tick_cnt_r;
    player_state_t         play_state_r, play_state_s;
    logic [RESOLUTION-1:0] dac_r;
    logic                  empty_s, full_s, tick_s;
    logic                  pop_s, wr_en_s, restart_s, underflow_s, overflow_s;
    logic                  underflow_r, overflow_r;

    assign empty_s = (wr_ptr_r == rd_ptr_r);
    assign full_s  = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign tick_s  = (tick_cnt_r == TICK_LAST);

    // Player FSM and FIFO pointer arithmetic; en_i low flushes everything.
    always_comb begin
        play_state_s = play_state_r;
        pop_s        = 1'b0;
        restart_s    = 1'b0;
        underflow_s  = 1'b0;
        if (!bus.en_i) begin
            play_state_s = PRIME;
        end else begin
            case (play_state_r)
                PRIME: begin
                    if (level_r >= PRIME_LEVEL) begin
                        play_state_s = PLAY;
                        restart_s    = 1'b1;
                    end else begin
                        play_state_s = PRIME;
                    end
                end
                PLAY: begin
                    if (tick_s && !empty_s) begin
                        pop_s = 1'b1;
                    end else if (tick_s) begin
                        underflow_s  = 1'b1;
                        play_state_s = PRIME;
                    end else begin
                        play_state_s = PLAY;
                    end
                end
                default: play_state_s = PRIME;
            endcase
        end
        // A full FIFO still accepts a push when a pop frees a slot this cycle.
        wr_en_s    = push_r && bus.en_i && (!full_s || pop_s);
        overflow_s = push_r && bus.en_i && full_s && !pop_s;
        if (!bus.en_i) begin
            wr_ptr_s = PTR_0;
            rd_ptr_s = PTR_0;
        end else begin
            wr_ptr_s = wr_ptr_r + (AW + 1)'(wr_en_s);
            rd_ptr_s = rd_ptr_r + (AW + 1)'(pop_s);
        end
    end

    // Player state, pointers, sample timer and DAC output register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            play_state_r <= PRIME;
            wr_ptr_r     <= PTR_0;
            rd_ptr_r     <= PTR_0;
            level_r      <= PTR_0;
            tick_cnt_r   <= TICK_0;
            dac_r        <= DAC_MIDSCALE;
            underflow_r  <= 1'b0;
            overflow_r   <= 1'b0;
        end else begin
            play_state_r <= play_state_s;
            wr_ptr_r     <= wr_ptr_s;
            rd_ptr_r     <= rd_ptr_s;
            level_r      <= wr_ptr_s - rd_ptr_s;
            underflow_r  <= underflow_s;
            overflow_r   <= overflow_s;
            if (!bus.en_i || restart_s || tick_s) begin
                tick_cnt_r <= TICK_0;
            end else begin
                tick_cnt_r <= tick_cnt_r + TW'(1'b1);
            end
            if (!bus.en_i) begin
                dac_r <= DAC_MIDSCALE;
            end else if (pop_s) begin
                dac_r <= mem_r[rd_ptr_r[AW-1:0]];
            end else begin
                dac_r <= dac_r;
            end
        end
    end

    // Sample storage; validity is defined by the pointers, so no reset.
    always_ff @(posedge clk_i) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= push_data_r;
        end
    end

    assign bus.dac_o       = dac_r;
    assign bus.playing_o   = (play_state_r == PLAY);
    assign bus.level_o     = level_r;
    assign bus.underflow_o = underflow_r;
    assign bus.overflow_o  = overflow_r;
    assign bus.frame_err_o = frame_err_r;

endmodule

// File: tb/tb_uart_dac_player.sv
// Directed bench for uart_dac_player at a scaled clock (10 clocks/bit, 3000-clock tick).
module tb_uart_dac_player;
    localparam int CPB  = 10;
    localparam int TICK = 3000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_dac_player_if #(.RESOLUTION(12), .FIFO_DEPTH(16)) bus ();

    uart_dac_player #(
        .CLK_FREQ    (1_152_000),
        .BAUD        (115_200),
        .SAMPLE_FREQ (384),
        .RESOLUTION  (12),
        .FIFO_DEPTH  (16)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus.slave)
    );

    typedef struct {
        logic [7:0]  hi_b;
        logic [7:0]  lo_b;
        logic [11:0] exp_dac;
    } play_vec_t;

    typedef struct {
        logic [7:0] b;
        logic       stop;
        int         d_ferr;
        int         exp_level;
    } byte_vec_t;

    int checks   = 0;
    int passes   = 0;
    int cyc      = 0;
    int ferr_cnt = 0;
    int ovf_cnt  = 0;
    int unf_cnt  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.frame_err_o) ferr_cnt <= ferr_cnt + 1;
        if (bus.overflow_o)  ovf_cnt  <= ovf_cnt + 1;
        if (bus.underflow_o) unf_cnt  <= unf_cnt + 1;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        bus.rx_i = 1'b0;
        step(CPB);
        for (int i = 0; i < 8; i++) begin
            bus.rx_i = b[i];
            step(CPB);
        end
        bus.rx_i = stop;
        step(CPB);
        bus.rx_i = 1'b1;
        step(2 * CPB);
    endtask

    task automatic send_frame(input logic [11:0] d);
        send_byte({2'b10, d[11:6]}, 1'b1);
        send_byte({2'b00, d[5:0]}, 1'b1);
    endtask

    task automatic wait_dac(input int budget, output logic [11:0] val, output int at);
        logic [11:0] prev;
        prev = bus.dac_o;
        val  = prev;
        at   = -1;
        for (int i = 0; i < budget; i++) begin
            step(1);
            if (bus.dac_o !== prev) begin
                val = bus.dac_o;
                at  = cyc;
                break;
            end
        end
        if (at < 0) begin
            checks++;
            $display("FAIL dac_wait: got no change, required a change within %0d cycles", budget);
        end
    endtask

    task automatic wait_unf(input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            step(1);
            if (bus.underflow_o === 1'b1) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) begin
            checks++;
            $display("FAIL unf_wait: got no pulse, required one within %0d cycles", budget);
        end
    endtask

    play_vec_t   play_tab [8];
    byte_vec_t   byte_tab [7];
    logic [11:0] val;
    int          at, last_at, base, bad;

    initial begin
        play_tab[0] = '{8'h80, 8'h00, 12'h000};
        play_tab[1] = '{8'hBF, 8'h3F, 12'hFFF};
        play_tab[2] = '{8'h84, 8'h23, 12'h123};
        play_tab[3] = '{8'hAA, 8'h3C, 12'hABC};
        play_tab[4] = '{8'hA0, 8'h00, 12'h800};
        play_tab[5] = '{8'h9F, 8'h3F, 12'h7FF};
        play_tab[6] = '{8'h80, 8'h01, 12'h001};
        play_tab[7] = '{8'hBF, 8'h3E, 12'hFFE};

        byte_tab[0] = '{8'h05, 1'b1, 1, 0};
        byte_tab[1] = '{8'h83, 1'b1, 0, 0};
        byte_tab[2] = '{8'h92, 1'b1, 1, 0};
        byte_tab[3] = '{8'h15, 1'b1, 0, 1};
        byte_tab[4] = '{8'hC0, 1'b0, 1, 1};
        byte_tab[5] = '{8'h8A, 1'b1, 0, 1};
        byte_tab[6] = '{8'h2A, 1'b1, 0, 2};

        bus.rx_i = 1'b1;
        bus.en_i = 1'b0;
        step(5);
        check("rst_dac", int'(bus.dac_o), 'h800);
        check("rst_playing", int'(bus.playing_o), 0);
        check("rst_level", int'(bus.level_o), 0);
        check("rst_pulses", int'({bus.underflow_o, bus.overflow_o, bus.frame_err_o}), 0);
        rst_n = 1'b1;

        // Idle with playback enabled: nothing may change.
        bus.en_i = 1'b1;
        bad = 0;
        for (int i = 0; i < 2000; i++) begin
            step(1);
            if (bus.dac_o !== 12'h800 || bus.playing_o !== 1'b0 || bus.level_o !== 5'd0) bad = 1;
        end
        check("idle_stable", bad, 0);

        // Eight frames, then timed playback ending in underflow.
        for (int i = 0; i < 8; i++) begin
            send_byte(play_tab[i].hi_b, 1'b1);
            send_byte(play_tab[i].lo_b, 1'b1);
            if (i == 6) check("playing_before_8th", int'(bus.playing_o), 0);
        end
        check("playing_after_8th", int'(bus.playing_o), 1);
        check("level_after_8th", int'(bus.level_o), 8);
        last_at = 0;
        for (int i = 0; i < 8; i++) begin
            wait_dac(2 * TICK, val, at);
            check($sformatf("play_val%0d", i), int'(val), int'(play_tab[i].exp_dac));
            if (i > 0) check($sformatf("play_gap%0d", i), at - last_at, TICK);
            last_at = at;
        end
        base = unf_cnt;
        wait_unf(2 * TICK, at);
        check("unf_gap", at - last_at, TICK);
        step(1);
        check("unf_count", unf_cnt - base, 1);
        check("unf_playing", int'(bus.playing_o), 0);
        check("unf_dac_hold", int'(bus.dac_o), 'hFFE);

        // Framing errors, adopted high byte, and a stop-bit error.
        for (int i = 0; i < 7; i++) begin
            base = ferr_cnt;
            send_byte(byte_tab[i].b, byte_tab[i].stop);
            check($sformatf("ferr_byte%0d", i), ferr_cnt - base, byte_tab[i].d_ferr);
            check($sformatf("level_byte%0d", i), int'(bus.level_o), byte_tab[i].exp_level);
        end

        // Fill to the prime level and confirm the stored samples play back.
        for (int i = 1; i <= 6; i++) send_frame(12'(i * 12'h111));
        check("fill_playing", int'(bus.playing_o), 1);
        wait_dac(2 * TICK, val, at);
        check("play_495", int'(val), 'h495);
        wait_dac(2 * TICK, val, at);
        check("play_2aa", int'(val), 'h2AA);
        wait_dac(2 * TICK, val, at);
        check("play_111", int'(val), 'h111);
        check("mid_play_level", int'(bus.level_o), 5);
        check("mid_play_playing", int'(bus.playing_o), 1);
        bus.en_i = 1'b0;
        step(1);
        check("dis_level", int'(bus.level_o), 0);
        check("dis_dac", int'(bus.dac_o), 'h800);
        check("dis_playing", int'(bus.playing_o), 0);

        // Saturate the FIFO: overflow only on the 17th frame.
        bus.en_i = 1'b1;
        base = ovf_cnt;
        for (int i = 0; i < 17; i++) begin
            send_frame(12'(i * 37 + 5));
            check($sformatf("sat_level%0d", i), int'(bus.level_o), (i + 1 > 16) ? 16 : i + 1);
            check($sformatf("sat_ovf%0d", i), ovf_cnt - base, (i == 16) ? 1 : 0);
        end

        // Asynchronous reset in the middle of a byte.
        bus.rx_i = 1'b0;
        step(35);
        rst_n = 1'b0;
        #1;
        check("arst_dac", int'(bus.dac_o), 'h800);
        check("arst_playing", int'(bus.playing_o), 0);
        check("arst_level", int'(bus.level_o), 0);
        check("arst_pulses", int'({bus.underflow_o, bus.overflow_o, bus.frame_err_o}), 0);
        step(3);
        bus.rx_i = 1'b1;
        bus.en_i = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(2);

        // Pushes are discarded while disabled, accepted once enabled.
        base = ferr_cnt;
        send_frame(12'h5A5);
        check("dis_push_level", int'(bus.level_o), 0);
        check("dis_push_ferr", ferr_cnt - base, 0);
        bus.en_i = 1'b1;
        send_frame(12'h123);
        check("en_push_level", int'(bus.level_o), 1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
